// File: rtl/sar_pkg.sv
// Shared SAR ADC constants and types: code width (also used by the SAR
// controller), default result-FIFO depth and averaging factor.
package sar_pkg;

  localparam int SAR_CODE_W     = 8;
  localparam int SAR_FIFO_DEPTH = 8;
  localparam int SAR_AVG_LOG2   = 2;

  typedef logic [SAR_CODE_W-1:0] sar_code_t;

endpackage

// File: rtl/sar_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers, level and full/empty.
// A push while full is ignored unless a pop happens in the same cycle.
module sar_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the head slot that wptr points at.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/sar_result_fifo.sv
// SAR result stage: EOC edge capture, optional decimating averager
// (compiled in with `define SAR_AVG_EN), result FIFO and sticky overflow.
module sar_result_fifo
  import sar_pkg::*;
#(
  parameter int DATA_W   = SAR_CODE_W,
  parameter int DEPTH    = SAR_FIFO_DEPTH,
  parameter int AVG_LOG2 = SAR_AVG_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   eoc,
  input  logic [DATA_W-1:0]      code_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  logic              eoc_d;
  logic              sample;
  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] rdata;
  logic              drop;

  // eoc_d resets high so an eoc already asserted at reset release is ignored.
  always_ff @(posedge clk) begin
    if (rst) eoc_d <= 1'b1;
    else     eoc_d <= eoc;
  end

  assign sample = eoc & ~eoc_d;

`ifdef SAR_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [AVG_LOG2-1:0] cnt;
  logic                last;

  assign sum       = acc + {{AVG_LOG2{1'b0}}, code_in};
  assign last      = (cnt == '1);
  assign push_req  = sample & last;
  assign push_data = sum[ACC_W-1:AVG_LOG2];

  // The averager restarts on the final sample even if the word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign push_req  = sample;
  assign push_data = code_in;
`endif

  assign pop  = m_valid & m_ready;
  assign drop = push_req & full & ~pop;

  sar_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (push_data),
    .pop   (pop),
    .rdata (rdata),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  assign m_valid = ~empty;
  assign m_data  = m_valid ? rdata : '0;

  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_sar_result_fifo.sv
// Self-checking bench for sar_result_fifo against a queue-based reference
// model; build with +define+SAR_AVG_EN to exercise the averager.
module tb_sar_result_fifo;
  import sar_pkg::*;

  localparam int DEPTH = SAR_FIFO_DEPTH;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SAR_AVG_EN
  localparam int NS = 1 << SAR_AVG_LOG2;
`else
  localparam int NS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          eoc = 1'b1;
  logic [7:0]    code_in = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clr_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored words, pending samples, sticky flag, last eoc.
  int mq[$];
  int msamp[$];
  bit movf  = 1'b0;
  bit meocd = 1'b1;

  sar_result_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .eoc      (eoc),
    .code_in  (code_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  // One clock edge; the model applies the same inputs the DUT saw.
  task automatic tick();
    bit pop, smp, push, drop;
    int word, sum;
    pop  = (mq.size() != 0) && m_ready;
    smp  = eoc && !meocd;
    push = 1'b0;
    word = 0;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      msamp.delete();
      movf  = 1'b0;
      meocd = 1'b1;
    end else begin
      meocd = eoc;
      if (smp) begin
        msamp.push_back(int'(code_in));
        if (msamp.size() == NS) begin
          sum = 0;
          foreach (msamp[i]) sum += msamp[i];
          word = sum / NS;
          push = 1'b1;
          msamp.delete();
        end
      end
      if (pop) void'(mq.pop_front());
      drop = 1'b0;
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(word);
        else drop = 1'b1;
      end
      if (drop) movf = 1'b1;
      else if (clr_ovf) movf = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; eoc = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse(input logic [7:0] code, input bit rdy, input bit clr);
    eoc = 1'b1; code_in = code; m_ready = rdy; clr_ovf = clr;
    tick();
    eoc = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    tick();
  endtask

  // Enough identical samples to produce exactly one output word.
  task automatic push_word(input logic [7:0] code, input bit rdy, input bit clr);
    for (int k = 0; k < NS - 1; k++) pulse(code, 1'b0, 1'b0);
    pulse(code, rdy, clr);
  endtask

  task automatic test_reset();
    rst = 1'b1; eoc = 1'b1; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (level !== '0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_out got v=%b d=%h exp v=0 d=00", m_valid, m_data);
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    eoc = 1'b0;
    tick();
    eoc = 1'b1; code_in = 8'hA5;
    tick();
`ifdef SAR_AVG_EN
    n_checks++;
    if (level !== '0) begin n_fail++; $display("FAIL first_sample_level got %0d exp 0", level); end
`else
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      n_fail++; $display("FAIL first_capture got v=%b d=%h exp v=1 d=a5", m_valid, m_data);
    end
`endif
    eoc = 1'b0;
    tick();
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 1; i <= 8; i++) push_word(8'(i), 1'b0, 1'b0);
    n_checks++;
    if (level !== LW'(8) || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fill got level=%0d ovf=%b exp level=8 ovf=0", level, overflow);
    end
    push_word(8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (level !== LW'(8) || overflow !== 1'b1) begin
      n_fail++; $display("FAIL drop got level=%0d ovf=%b exp level=8 ovf=1", level, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_fail++; $display("FAIL drain_order got v=%b d=%h exp v=1 d=%h", m_valid, m_data, 8'(i));
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
    n_checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || level !== '0) begin
      n_fail++; $display("FAIL empty_after_drain got v=%b d=%h l=%0d exp 0/00/0", m_valid, m_data, level);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i), 1'b0, 1'b0);
    push_word(8'hEE, 1'b1, 1'b0);
    n_checks++;
    if (level !== LW'(8) || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_push_pop got level=%0d ovf=%b exp level=8 ovf=0", level, overflow);
    end
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] exp;
      exp = (i == 8) ? 8'hEE : 8'(8'h10 + i);
      n_checks++;
      if (m_data !== exp) begin
        n_fail++; $display("FAIL full_push_pop_order got %h exp %h", m_data, exp);
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
    end
  endtask

  task automatic test_ready_pattern();
    logic [7:0] pushed[$];
    logic [7:0] got[$];
    logic [7:0] held;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] c;
      c = 8'($urandom_range(0, 255));
      pushed.push_back(c);
      push_word(c, 1'b0, 1'b0);
    end
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      held = m_data;
      if (m_valid && m_ready) got.push_back(m_data);
      tick();
      if (i % 2 == 1) begin
        n_checks++;
        if (m_data !== held) begin
          n_fail++; $display("FAIL hold_stable got %h exp %h", m_data, held);
        end
      end
    end
    m_ready = 1'b0;
    n_checks++;
    if (got != pushed) begin
      n_fail++; $display("FAIL ready_pattern_seq got %p exp %p", got, pushed);
    end
  endtask

`ifdef SAR_AVG_EN
  task automatic test_avg();
    do_reset();
    pulse(8'd10, 1'b0, 1'b0);
    pulse(8'd11, 1'b0, 1'b0);
    pulse(8'd12, 1'b0, 1'b0);
    n_checks++;
    if (level !== '0) begin n_fail++; $display("FAIL avg_early got level=%0d exp 0", level); end
    pulse(8'd14, 1'b0, 1'b0);
    n_checks++;
    if (level !== LW'(1) || m_data !== 8'd11) begin
      n_fail++; $display("FAIL avg_word got level=%0d d=%0d exp level=1 d=11", level, m_data);
    end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (level !== LW'(1) || m_data !== 8'hFF) begin
      n_fail++; $display("FAIL avg_max got level=%0d d=%h exp level=1 d=ff", level, m_data);
    end
  endtask
`endif

  task automatic test_ovf_clear();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i), 1'b0, 1'b0);
    push_word(8'h33, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
    push_word(8'h44, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0 || level !== LW'(8) || m_data !== 8'h40) begin
      n_fail++; $display("FAIL ovf_clear got ovf=%b l=%0d d=%h exp 0/8/40", overflow, level, m_data);
    end
  endtask

  task automatic test_random();
    int gap = 0;
    int hold = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_checks++;
      if (m_valid !== (mq.size() != 0) || level !== LW'(mq.size()) ||
          m_data !== ((mq.size() != 0) ? 8'(mq[0]) : 8'h00) || overflow !== movf) begin
        n_fail++;
        $display("FAIL random cyc=%0d got v=%b d=%h l=%0d o=%b exp v=%b d=%h l=%0d o=%b",
                 cyc, m_valid, m_data, level, overflow, (mq.size() != 0),
                 (mq.size() != 0) ? 8'(mq[0]) : 8'h00, mq.size(), movf);
      end
      if (eoc) begin
        if (hold > 0) hold--;
        else begin eoc = 1'b0; gap = $urandom_range(0, 12); end
      end else if (gap > 0) gap--;
      else begin
        eoc = 1'b1; code_in = 8'($urandom_range(0, 255)); hold = $urandom_range(0, 2);
      end
      m_ready = (cyc < 600) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; eoc = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_ready_pattern();
`ifdef SAR_AVG_EN
    test_avg();
`endif
    test_ovf_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_result_fifo.md
# sar_result_fifo

Downstream result stage for the SAR ADC: captures each completed 8-bit conversion code when the SAR controller raises EOC and buffers it in a small synchronous FIFO. Words are presented to the system on a valid/ready stream interface. An optional decimating averager combines 2^AVG_LOG2 consecutive conversions into one output word. A sticky overflow flag records any result lost because the FIFO was full.

## Interface
- DATA_W, 8: conversion code width; equals the SAR DAC code width.
- DEPTH, 8: FIFO depth in words; power of two, minimum 2.
- AVG_LOG2, 2: log2 of samples per averaged word; used only when averaging is compiled in; minimum 1.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- eoc  in  1  end-of-conversion from the SAR controller; a capture occurs on its rising edge.
- code_in  in  DATA_W  conversion code; stable while eoc is high.
- m_valid  out  1  FIFO head word available.
- m_ready  in  1  consumer accepts m_data.
- m_data  out  DATA_W  FIFO head word; forced to 0 while m_valid is 0.
- level  out  $clog2(DEPTH)+1  number of stored words.
- overflow  out  1  sticky flag; a result was dropped.
- clr_ovf  in  1  clears overflow.

## Operation
- Edge detection:
  - eoc_d registers eoc every cycle.
  - sample = eoc & ~eoc_d.
  - eoc_d resets to 1, so an eoc already high when rst deasserts is not captured.
- Push source, averaging compiled out: every sample pushes code_in.
- Push source, averaging compiled in:
  - Accumulator is DATA_W+AVG_LOG2 bits wide. A sample counter counts 0 … 2^AVG_LOG2−1.
  - On a non-final sample: acc += code_in; counter increments.
  - On the final sample: push (acc + code_in) >> AVG_LOG2, truncated toward zero, not rounded. acc and counter then return to 0.
  - The accumulator cannot overflow.
- Pop: occurs when m_valid & m_ready.
- Push when full and no pop in the same cycle:
  - The word is dropped and overflow is set to 1.
  - FIFO contents and pointers are unchanged.
  - The averager still restarts.
- Push and pop in the same cycle while full: both are performed, level is unchanged, and there is no overflow.
- Push while empty: m_valid is 0 that cycle, so no pop can occur.
- Pointers wrap modulo DEPTH. Full is level==DEPTH; empty is level==0.
- Overflow flag update:
  - Set by a dropped push.
  - Cleared by clr_ovf.
  - A set and clr_ovf in the same cycle leave overflow at 1.
- rst at any time, including mid-averaging or with the FIFO full:
  - Discards all stored words and the partial sum.
  - Does not require the memory array itself to be cleared.

## Timing
- Reset values:
  - m_valid 0, m_data 0, level 0, overflow 0.
  - Read/write pointers 0, acc 0, sample counter 0, eoc_d 1.
- Capture latency: a push at edge k gives m_valid=1 with the pushed word on m_data after edge k, i.e. one cycle.
- Stream handshake:
  - m_data and m_valid are held stable while m_valid & ~m_ready.
  - The next word appears in the cycle after a pop.
- Throughput: one push and one pop per cycle maximum. The SAR produces at most one sample per 10 clocks.
- level updates at the same edge as the push or pop.

## Configuration
- Macro SAR_AVG_EN:
  - Defined: the averager is present and AVG_LOG2 is honoured; one word is pushed per 2^AVG_LOG2 samples.
  - Undefined: no accumulator or counter logic; every sample is pushed unmodified; AVG_LOG2 is ignored.

## Structure
- Package sar_pkg holds:
  - SAR_CODE_W = 8, shared with the SAR controller.
  - Default FIFO depth and AVG_LOG2 constants.
  - The typedef sar_code_t.
- Sub-module sar_sync_fifo:
  - Storage, pointers, level, and full/empty.
  - Interface: push/pop with write/read data.
- The top level holds edge detection, the averager and the overflow flag.

## Test plan
- Reset release with eoc already high: no push occurs; level stays 0. A later eoc pulse with code_in=0xA5 gives m_valid=1 and m_data=0xA5 one cycle after the rising edge.
- Push 8 codes 0x01…0x08 with m_ready=0: level=8, overflow=0. A 9th code 0xFF is dropped and sets overflow=1. Draining then yields exactly 0x01…0x08 in order, and m_data=0 once empty.
- FIFO full with m_ready=1 and an eoc edge in the same cycle: level stays 8, overflow stays 0, and the new word is at the tail.
- Pattern m_ready=1,0,1,0 during a drain: m_data is held stable on each not-ready cycle and no word is duplicated or skipped.
- With SAR_AVG_EN, AVG_LOG2=2, codes 10, 11, 12, 14: exactly one word, 11, is pushed, and only after the 4th sample. Codes 0xFF×4 give 0xFF.
- Overflow set, then clr_ovf pulsed in the same cycle as a new dropped push: overflow stays 1. A clr_ovf pulse alone then clears it to 0.
